i2c_target_stretch: RTL and testbench

//  I2C target (responder) write-path: samples bus SCL/SDA, detects START/STOP, matches 7-bit address,

---
 rtl/i2c_target_stretch.sv | 187 ++++++++++++++++++
 tb/tb_i2c_target_stretch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_stretch.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_stretch
//  Description : I2C write-only target. Matches a 7-bit address, ACKs, and
//                holds SCL low after each data byte until the consumer takes it.
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_target_stretch #(
    parameter logic [6:0] ADDR    = 7'h50,
    parameter int         SETUP   = 4,
    parameter int         TIMEOUT = 8000,
    parameter int         CBITS   = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_drive_low,
    output logic       sda_drive_low,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       addr_hit,
    output logic       start_det,
    output logic       stop_det,
    output logic       err_timeout
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ADDR_ACK = 3'd2;
    localparam logic [2:0] S_RX       = 3'd3;
    localparam logic [2:0] S_STRETCH  = 3'd4;
    localparam logic [2:0] S_DATA_ACK = 3'd5;
    localparam logic [2:0] S_IGNORE   = 3'd6;

    localparam logic [CBITS-1:0] C_TMO_LAST   = CBITS'(TIMEOUT - 1);
    localparam logic [CBITS-1:0] C_SETUP_LAST = CBITS'(SETUP - 1);

    logic             r_scl_s1, r_scl_s2, r_scl_d;
    logic             r_sda_s1, r_sda_s2, r_sda_d;
    logic [2:0]       r_state, w_next;
    logic [7:0]       r_shift;
    logic [2:0]       r_bitcnt;
    logic             r_full;
    logic [CBITS-1:0] r_cnt;
    logic             r_acked;
    logic             r_pend;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_addr_hit;
    logic             r_start_det, r_stop_det, r_err;

    logic             w_scl_rise, w_scl_fall, w_start, w_stop;
    logic             w_hs, w_match, w_timeout, w_setup_done;
    logic [CBITS-1:0] w_cnt_inc;

    assign w_scl_rise   = r_scl_s2 & ~r_scl_d;
    assign w_scl_fall   = ~r_scl_s2 & r_scl_d;
    assign w_start      = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
    assign w_stop       = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
    assign w_hs         = r_rx_valid & rx_ready;
    assign w_match      = (r_shift[7:1] == ADDR) & ~r_shift[0];
    assign w_cnt_inc    = (r_cnt == {CBITS{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    assign w_setup_done = (r_state == S_STRETCH) & r_acked & (r_cnt == C_SETUP_LAST);
    assign w_timeout    = (r_state == S_STRETCH) & ~r_acked & ~w_hs & (r_cnt == C_TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_start) begin
            w_next = S_ADDR;
        end else if (w_stop) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_ADDR:     if (w_scl_fall && r_full) w_next = w_match ? S_ADDR_ACK : S_IGNORE;
                S_ADDR_ACK: if (w_scl_fall) w_next = S_RX;
                S_RX:       if (w_scl_fall && r_full) w_next = S_STRETCH;
                S_STRETCH: begin
                    if (w_setup_done)   w_next = S_DATA_ACK;
                    else if (w_timeout) w_next = S_IGNORE;
                end
                S_DATA_ACK: if (w_scl_fall) w_next = S_RX;
                default:    w_next = r_state;
            endcase
        end
    end

    always_comb begin
        sda_drive_low = (r_state == S_ADDR_ACK) || (r_state == S_DATA_ACK) ||
                        ((r_state == S_STRETCH) && r_acked);
        scl_drive_low = (r_state == S_STRETCH);
        rx_data       = r_rx_data;
        rx_valid      = r_rx_valid;
        addr_hit      = r_addr_hit;
        start_det     = r_start_det;
        stop_det      = r_stop_det;
        err_timeout   = r_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
            {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
            r_shift     <= 8'h00;
            r_bitcnt    <= 3'd0;
            r_full      <= 1'b0;
            r_cnt       <= '0;
            r_acked     <= 1'b0;
            r_pend      <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_addr_hit  <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            {r_scl_s1, r_scl_s2, r_scl_d} <= {scl_in, r_scl_s1, r_scl_s2};
            {r_sda_s1, r_sda_s2, r_sda_d} <= {sda_in, r_sda_s1, r_sda_s2};
            r_start_det <= w_start;
            r_stop_det  <= w_stop;
            r_err       <= w_timeout;
            if (w_hs) r_rx_valid <= 1'b0;
            if (w_start || w_stop) begin
                r_bitcnt   <= 3'd0;
                r_full     <= 1'b0;
                r_acked    <= 1'b0;
                r_pend     <= 1'b0;
                r_addr_hit <= 1'b0;
            end else begin
                if (w_scl_rise && (r_state == S_ADDR || r_state == S_RX)) begin
                    r_shift  <= {r_shift[6:0], r_sda_s2};
                    r_bitcnt <= r_bitcnt + 3'd1;
                    r_full   <= (r_bitcnt == 3'd7);
                end
                if (w_scl_fall) r_full <= 1'b0;
                case (r_state)
                    S_ADDR_ACK: if (w_scl_fall) r_addr_hit <= 1'b1;
                    S_RX: begin
                        // An unaccepted previous byte stays put; the new one waits in r_shift.
                        if (w_scl_fall && r_full) begin
                            r_cnt   <= '0;
                            r_acked <= 1'b0;
                            if (r_rx_valid) begin
                                r_pend <= 1'b1;
                            end else begin
                                r_rx_data  <= r_shift;
                                r_rx_valid <= 1'b1;
                            end
                        end
                    end
                    S_STRETCH: begin
                        if (r_acked) begin
                            r_cnt <= w_cnt_inc;
                            if (w_setup_done) r_acked <= 1'b0;
                        end else if (w_timeout) begin
                            r_rx_valid <= 1'b0;
                            r_pend     <= 1'b0;
                        end else if (r_pend) begin
                            if (!r_rx_valid) begin
                                r_rx_data  <= r_shift;
                                r_rx_valid <= 1'b1;
                                r_pend     <= 1'b0;
                                r_cnt      <= '0;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else if (w_hs) begin
                            r_acked <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_stretch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_i2c_target_stretch
//  Description : Directed bench; the bench plays the I2C controller and consumer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_target_stretch;

    localparam int SETUP   = 4;
    localparam int TIMEOUT = 8000;
    localparam int LO      = 8;
    localparam int HI      = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       ctl_scl, ctl_sda, rx_ready;
    logic       scl_in, sda_in;
    logic       scl_drive_low, sda_drive_low;
    logic [7:0] rx_data;
    logic       rx_valid, addr_hit, start_det, stop_det, err_timeout;

    i2c_target_stretch #(.ADDR(7'h50), .SETUP(SETUP), .TIMEOUT(TIMEOUT), .CBITS(13)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
        .scl_drive_low(scl_drive_low), .sda_drive_low(sda_drive_low),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .addr_hit(addr_hit), .start_det(start_det), .stop_det(stop_det),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Open-drain wired-AND of controller and target.
    assign scl_in = ctl_scl & ~scl_drive_low;
    assign sda_in = ctl_sda & ~sda_drive_low;

    int checks = 0, failures = 0;
    int n_start = 0, n_stop = 0, n_err = 0, n_stretch = 0, n_acc = 0;
    int run = 0, last_stretch = 0, n_sda_cyc = 0, viol = 0;
    logic [7:0] cap = 8'h00;
    logic prev_sda = 1'b0;

    always @(posedge clk) begin
        if (start_det) n_start <= n_start + 1;
        if (stop_det) n_stop <= n_stop + 1;
        if (err_timeout) n_err <= n_err + 1;
        if (sda_drive_low) n_sda_cyc <= n_sda_cyc + 1;
        if (rx_valid && rx_ready) begin
            cap   <= rx_data;
            n_acc <= n_acc + 1;
        end
        if (scl_drive_low) begin
            run <= run + 1;
        end else if (run != 0) begin
            last_stretch <= run;
            n_stretch    <= n_stretch + 1;
            run          <= 0;
        end
    end

    always @(negedge clk) begin
        if (!rst && sda_drive_low !== prev_sda && scl_in === 1'b1) viol <= viol + 1;
        prev_sda <= sda_drive_low;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_scl_high(input int limit);
        int n;
        n = 0;
        while (scl_in !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("scl_release_wait", 32'(n < limit), 32'd1);
    endtask

    task automatic send_bit(input logic b, output logic s, input int limit);
        ctl_sda = b;
        tick(LO);
        ctl_scl = 1'b1;
        wait_scl_high(limit);
        tick(HI);
        s = sda_in;
        ctl_scl = 1'b0;
        tick(2);
    endtask

    task automatic send_byte(input logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(d[i], s, 50);
    endtask

    task automatic get_ack(output logic a, input int limit);
        send_bit(1'b1, a, limit);
    endtask

    task automatic start_c();
        ctl_sda = 1'b1;
        tick(2);
        ctl_scl = 1'b1;
        wait_scl_high(50);
        tick(HI);
        ctl_sda = 1'b0;
        tick(HI);
        ctl_scl = 1'b0;
        tick(2);
    endtask

    task automatic stop_c();
        ctl_sda = 1'b0;
        tick(LO);
        ctl_scl = 1'b1;
        wait_scl_high(50);
        tick(HI);
        ctl_sda = 1'b1;
        tick(HI);
    endtask

    initial begin
        logic a;
        logic s;
        int   base_start, base_stop, base_str, base_sda, base_acc, base_err;
        rst = 1'b1; ctl_scl = 1'b1; ctl_sda = 1'b1; rx_ready = 1'b0;
        tick(4);
        chk("reset_outs", 32'({scl_drive_low, sda_drive_low, rx_valid, addr_hit,
                               start_det, stop_det, err_timeout}), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'h00);
        rst = 1'b0;
        tick(4);

        // Basic write 0xA0 / 0x3C, consumer always ready
        rx_ready = 1'b1;
        base_start = n_start;
        start_c();
        chk("t1_start_det", 32'(n_start - base_start), 32'd1);
        send_byte(8'hA0);
        get_ack(a, 50);
        chk("t1_addr_ack", 32'(a), 32'd0);
        tick(4);
        chk("t1_addr_hit", 32'(addr_hit), 32'd1);
        base_acc = n_acc;
        send_byte(8'h3C);
        get_ack(a, 100);
        chk("t1_data_ack", 32'(a), 32'd0);
        chk("t1_rx_data", 32'(rx_data), 32'h3C);
        chk("t1_captured", 32'(cap), 32'h3C);
        chk("t1_accepts", 32'(n_acc - base_acc), 32'd1);
        chk("t1_stretch_len", 32'(last_stretch), 32'(SETUP + 1));
        base_stop = n_stop;
        stop_c();
        tick(4);
        chk("t1_stop_det", 32'(n_stop - base_stop), 32'd1);
        chk("t1_addr_hit_clr", 32'(addr_hit), 32'd0);

        // Wrong address, then read address: never driven, never stretched
        base_str = n_stretch; base_sda = n_sda_cyc;
        start_c();
        send_byte(8'hA2);
        get_ack(a, 50);
        chk("t2_nack", 32'(a), 32'd1);
        send_byte(8'h12);
        get_ack(a, 50);
        chk("t2_data_nack", 32'(a), 32'd1);
        chk("t2_addr_hit", 32'(addr_hit), 32'd0);
        chk("t2_rx_valid", 32'(rx_valid), 32'd0);
        stop_c();
        start_c();
        send_byte(8'hA1);
        get_ack(a, 50);
        chk("t3_read_nack", 32'(a), 32'd1);
        send_byte(8'hFF);
        get_ack(a, 50);
        chk("t3_data_nack", 32'(a), 32'd1);
        stop_c();
        chk("t23_no_stretch", 32'(n_stretch - base_str), 32'd0);
        chk("t23_no_sda_drive", 32'(n_sda_cyc - base_sda), 32'd0);

        // Consumer stalls 500 clk after byte 0x55
        rx_ready = 1'b0;
        start_c();
        send_byte(8'hA0);
        get_ack(a, 50);
        chk("t4_addr_ack", 32'(a), 32'd0);
        send_byte(8'h55);
        fork
            get_ack(a, 1000);
            begin : b_consumer
                int n;
                n = 0;
                while (!rx_valid && n < 20) begin
                    tick(1);
                    n++;
                end
                chk("t4_valid_seen", 32'(rx_valid), 32'd1);
                tick(500);
                chk("t4_scl_held", 32'(scl_drive_low), 32'd1);
                chk("t4_rx_data", 32'(rx_data), 32'h55);
                rx_ready = 1'b1;
            end
        join
        chk("t4_data_ack", 32'(a), 32'd0);
        chk("t4_stretch_len", 32'(last_stretch), 32'(500 + SETUP + 1));
        chk("t4_valid_clr", 32'(rx_valid), 32'd0);
        send_byte(8'h81);
        get_ack(a, 100);
        chk("t4_resume_ack", 32'(a), 32'd0);
        chk("t4_resume_cap", 32'(cap), 32'h81);
        stop_c();

        // Consumer never ready: timeout drops the byte and NACKs
        rx_ready = 1'b0;
        start_c();
        send_byte(8'hA0);
        get_ack(a, 50);
        base_err = n_err;
        send_byte(8'h99);
        get_ack(a, TIMEOUT + 1000);
        chk("t5_nack", 32'(a), 32'd1);
        chk("t5_stretch_len", 32'(last_stretch), 32'(TIMEOUT));
        chk("t5_err_pulse", 32'(n_err - base_err), 32'd1);
        chk("t5_rx_valid", 32'(rx_valid), 32'd0);
        base_str = n_stretch;
        send_byte(8'h5A);
        get_ack(a, 50);
        chk("t5_ignored_nack", 32'(a), 32'd1);
        chk("t5_ignored_nostr", 32'(n_stretch - base_str), 32'd0);
        stop_c();

        // Repeated START after 3 data bits, then reset mid-stretch
        rx_ready = 1'b1;
        start_c();
        send_byte(8'hA0);
        get_ack(a, 50);
        send_bit(1'b1, s, 50);
        send_bit(1'b0, s, 50);
        send_bit(1'b1, s, 50);
        base_start = n_start;
        start_c();
        chk("t6_rstart_det", 32'(n_start - base_start), 32'd1);
        chk("t6_addr_hit_clr", 32'(addr_hit), 32'd0);
        send_byte(8'hA0);
        get_ack(a, 50);
        chk("t6_addr_ack", 32'(a), 32'd0);
        send_byte(8'hC3);
        get_ack(a, 100);
        chk("t6_data_ack", 32'(a), 32'd0);
        chk("t6_cap", 32'(cap), 32'hC3);
        rx_ready = 1'b0;
        send_byte(8'h7E);
        tick(10);
        chk("t6_stretching", 32'(scl_drive_low), 32'd1);
        chk("t6_rx_data", 32'(rx_data), 32'h7E);
        rst = 1'b1;
        tick(1);
        chk("t6_rst_outs", 32'({scl_drive_low, sda_drive_low, rx_valid, addr_hit}), 32'd0);
        chk("t6_rst_data", 32'(rx_data), 32'h00);
        rst = 1'b0;
        base_stop = n_stop;
        stop_c();
        tick(4);
        chk("t6_stop_det", 32'(n_stop - base_stop), 32'd1);
        chk("sda_change_while_scl_high", 32'(viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
